// File: rtl/spectrum_pkg.sv
// Shared types and helpers for the spectrum band engine.
package spectrum_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_OUT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/band_scale_peak.sv
// Scales a band sum with saturation and folds it into a decaying peak-hold.
module band_scale_peak
  import spectrum_pkg::*;
#(
  parameter int unsigned ACC_W      = 19,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned OUT_SHIFT  = 11,
  parameter int unsigned DECAY_STEP = 4
) (
  input  logic [ACC_W-1:0]     i_sum,
  input  logic [OUT_WIDTH-1:0] i_peak,
  output logic [OUT_WIDTH-1:0] o_band_c,
  output logic [OUT_WIDTH-1:0] o_peak_c
);

  localparam logic [ACC_W-1:0]     SAT_MAX = ACC_W'((64'd1 << OUT_WIDTH) - 64'd1);
  localparam logic [OUT_WIDTH-1:0] DECAY   = OUT_WIDTH'(DECAY_STEP);

  logic [ACC_W-1:0]     w_shifted;
  logic [OUT_WIDTH-1:0] w_decayed;

  // Saturating scale, then decay the old peak and keep the larger value.
  always_comb begin
    w_shifted = i_sum >> OUT_SHIFT;
    o_band_c  = (w_shifted > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] : w_shifted[OUT_WIDTH-1:0];
    w_decayed = (i_peak > DECAY) ? (i_peak - DECAY) : '0;
    o_peak_c  = (o_band_c > w_decayed) ? o_band_c : w_decayed;
  end

endmodule

// File: rtl/spectrum_band_engine.sv
// Streaming band-energy analyser: per-band |x| sums, scaling, peak-hold, band stream out.
module spectrum_band_engine
  import spectrum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned BAND_NUM   = 8,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned OUT_SHIFT  = DATA_WIDTH + clog2(FRAME_LEN / BAND_NUM) - OUT_WIDTH,
  parameter int unsigned DECAY_STEP = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         continuous,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic [OUT_WIDTH-1:0]         band_data,
  output logic [OUT_WIDTH-1:0]         band_peak,
  output logic [clog2(BAND_NUM)-1:0]   band_idx,
  output logic                         band_valid,
  input  logic                         band_ready,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned SPB   = FRAME_LEN / BAND_NUM;
  localparam int unsigned SPB_W = clog2(SPB);
  localparam int unsigned ACC_W = DATA_WIDTH + SPB_W;
  localparam int unsigned CNT_W = clog2(FRAME_LEN);
  localparam int unsigned IDX_W = clog2(BAND_NUM);

  state_t r_state;
  state_t w_state_next;

  logic                 r_cont;
  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_W-1:0]     r_acc;
  logic [OUT_WIDTH-1:0] r_band [BAND_NUM];
  logic [OUT_WIDTH-1:0] r_peak [BAND_NUM];
  logic [IDX_W-1:0]     r_idx;
  logic                 r_band_valid;
  logic                 r_sample_ready;
  logic                 r_busy;
  logic                 r_frame_done;
  logic                 r_overrun;

  logic                 w_start_frame;
  logic                 w_accept;
  logic                 w_handshake;
  logic                 w_emit_last;
  logic [DATA_WIDTH:0]  w_sext;
  logic [DATA_WIDTH:0]  w_abs;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_band_end;
  logic [IDX_W-1:0]     w_cur_band;
  logic [OUT_WIDTH-1:0] w_band_new;
  logic [OUT_WIDTH-1:0] w_peak_new;

  // Magnitude at one extra bit so the most negative sample maps cleanly.
  assign w_sext     = {sample_in[DATA_WIDTH-1], sample_in};
  assign w_abs      = sample_in[DATA_WIDTH-1] ? (~w_sext + 1'b1) : w_sext;
  assign w_sum      = r_acc + ACC_W'(w_abs);
  assign w_band_end = &r_cnt[SPB_W-1:0];
  assign w_cur_band = r_cnt[CNT_W-1:SPB_W];

  band_scale_peak #(
    .ACC_W      (ACC_W),
    .OUT_WIDTH  (OUT_WIDTH),
    .OUT_SHIFT  (OUT_SHIFT),
    .DECAY_STEP (DECAY_STEP)
  ) u_scale (
    .i_sum    (w_sum),
    .i_peak   (r_peak[w_cur_band]),
    .o_band_c (w_band_new),
    .o_peak_c (w_peak_new)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_next  = r_state;
    w_start_frame = 1'b0;
    w_accept      = 1'b0;
    w_handshake   = 1'b0;
    w_emit_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_frame = 1'b1;
          w_state_next  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (sample_valid) begin
          w_accept = 1'b1;
          if (&r_cnt) w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (band_ready) begin
          w_handshake = 1'b1;
          if (r_idx == IDX_W'(BAND_NUM - 1)) begin
            w_emit_last  = 1'b1;
            w_state_next = r_cont ? ST_COLLECT : ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Registered status outputs, band index and mode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cont         <= 1'b0;
      r_idx          <= '0;
      r_band_valid   <= 1'b0;
      r_sample_ready <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_band_valid   <= (w_state_next == ST_EMIT);
      r_sample_ready <= (w_state_next == ST_COLLECT);
      r_busy         <= (w_state_next != ST_IDLE);
      r_frame_done   <= w_emit_last;
      if (w_start_frame) begin
        r_cont    <= continuous;
        r_idx     <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_handshake) r_idx <= r_idx + 1'b1;
        if ((r_state == ST_EMIT) && sample_valid) r_overrun <= 1'b1;
      end
    end
  end

  // Accumulate magnitudes; commit band value and peak on each band's last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(BAND_NUM); i++) begin
        r_band[i] <= '0;
        r_peak[i] <= '0;
      end
    end else if (w_start_frame) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_band_end) begin
        r_acc              <= '0;
        r_band[w_cur_band] <= w_band_new;
        r_peak[w_cur_band] <= w_peak_new;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  assign sample_ready = r_sample_ready;
  assign band_valid   = r_band_valid;
  assign band_idx     = r_idx;
  assign band_data    = r_band[r_idx];
  assign band_peak    = r_peak[r_idx];
  assign frame_done   = r_frame_done;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_spectrum_band_engine.sv
// Randomised bench for spectrum_band_engine with a frame-level reference model.
module tb_spectrum_band_engine;

  localparam int DW     = 16;
  localparam int FL     = 64;
  localparam int BN     = 8;
  localparam int SPB    = 8;
  localparam int OW     = 8;
  localparam int BUDGET = 2000;
  localparam int PH_IDLE = 0;
  localparam int PH_COL  = 1;
  localparam int PH_EMIT = 2;

  logic clk = 1'b0;
  logic rst, start, continuous, sample_valid, band_ready;
  logic signed [DW-1:0] sample_in;

  logic          sample_ready0, band_valid0, frame_done0, busy0, overrun0;
  logic [OW-1:0] band_data0, band_peak0;
  logic [2:0]    band_idx0;
  logic          sample_ready1, band_valid1, frame_done1, busy1, overrun1;
  logic [OW-1:0] band_data1, band_peak1;
  logic [2:0]    band_idx1;

  spectrum_band_engine dut0 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready0),
    .band_data(band_data0), .band_peak(band_peak0), .band_idx(band_idx0),
    .band_valid(band_valid0), .band_ready(band_ready), .frame_done(frame_done0),
    .busy(busy0), .overrun(overrun0)
  );

  spectrum_band_engine #(.OUT_SHIFT(10)) dut1 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready1),
    .band_data(band_data1), .band_peak(band_peak1), .band_idx(band_idx1),
    .band_valid(band_valid1), .band_ready(band_ready), .frame_done(frame_done1),
    .busy(busy1), .overrun(overrun1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view from the accepted sample list.
  int m_phase, m_idx;
  bit m_cont, m_over, m_done;
  int m_band [2][BN];
  int m_peak [2][BN];
  logic signed [DW-1:0] m_q[$];

  task automatic m_reset();
    m_phase = PH_IDLE; m_idx = 0; m_cont = 0; m_over = 0; m_done = 0;
    m_q.delete();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < BN; b++) begin
        m_band[d][b] = 0;
        m_peak[d][b] = 0;
      end
  endtask

  task automatic m_finish_frame();
    for (int b = 0; b < BN; b++) begin
      int sum;
      sum = 0;
      for (int k = 0; k < SPB; k++) begin
        int v;
        v = int'(m_q[b*SPB+k]);
        sum += (v < 0) ? -v : v;
      end
      for (int d = 0; d < 2; d++) begin
        int sh, bv, dec;
        sh  = (d == 0) ? 11 : 10;
        bv  = sum >> sh;
        if (bv > 255) bv = 255;
        dec = (m_peak[d][b] > 4) ? m_peak[d][b] - 4 : 0;
        m_band[d][b] = bv;
        m_peak[d][b] = (bv > dec) ? bv : dec;
      end
    end
  endtask

  task automatic m_step();
    m_done = 0;
    case (m_phase)
      PH_IDLE: if (start) begin
        m_cont = continuous; m_over = 0; m_idx = 0; m_q.delete(); m_phase = PH_COL;
      end
      PH_COL: if (sample_valid) begin
        m_q.push_back(sample_in);
        if (m_q.size() == FL) begin
          m_finish_frame();
          m_q.delete();
          m_idx = 0;
          m_phase = PH_EMIT;
        end
      end
      default: begin
        if (sample_valid) m_over = 1;
        if (band_ready) begin
          if (m_idx == BN - 1) begin
            m_done = 1; m_idx = 0;
            m_phase = m_cont ? PH_COL : PH_IDLE;
          end else m_idx++;
        end
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("band_valid0",   int'(band_valid0),   int'(m_phase == PH_EMIT));
    chk("sample_ready0", int'(sample_ready0), int'(m_phase == PH_COL));
    chk("busy0",         int'(busy0),         int'(m_phase != PH_IDLE));
    chk("frame_done0",   int'(frame_done0),   int'(m_done));
    chk("overrun0",      int'(overrun0),      int'(m_over));
    chk("band_idx0",     int'(band_idx0),     m_idx);
    chk("band_valid1",   int'(band_valid1),   int'(m_phase == PH_EMIT));
    chk("frame_done1",   int'(frame_done1),   int'(m_done));
    chk("band_idx1",     int'(band_idx1),     m_idx);
    if (m_phase == PH_EMIT) begin
      chk("band_data0", int'(band_data0), m_band[0][m_idx]);
      chk("band_peak0", int'(band_peak0), m_peak[0][m_idx]);
      chk("band_data1", int'(band_data1), m_band[1][m_idx]);
      chk("band_peak1", int'(band_peak1), m_peak[1][m_idx]);
    end
  end

  int cap_d0 [BN];
  int cap_p0 [BN];
  int cap_d1 [BN];
  int hs_order [BN];

  function automatic logic signed [DW-1:0] gen(input int pat, input int i);
    logic signed [DW-1:0] v;
    case (pat)
      0: v = 16'h1000;
      1: v = (i / SPB == 3) ? 16'h8000 : 16'h0000;
      2: v = (i / SPB == 3) ? 16'h7FFF : 16'h0000;
      3: v = (i / SPB == 0) ? 16'h7FFF : 16'h0000;
      4: v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic do_start(input bit cont);
    start = 1'b1; continuous = cont; sample_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer samples (with optional gaps and stray start pulses) until n_feed accepted.
  task automatic feed(input int pat, input int n_feed, input int gap);
    int n, cyc;
    n = 0; cyc = 0;
    while (n < n_feed) begin
      bit offer;
      if (cyc >= BUDGET) begin chk("feed_timeout", n, n_feed); break; end
      offer = (gap == 0) || (int'($urandom_range(99)) >= gap);
      sample_valid = offer;
      sample_in = gen(pat, n);
      start = ($urandom_range(31) == 0);
      if (offer && sample_ready0) n++;
      @(negedge clk); cyc++;
    end
    start = 1'b0; sample_valid = 1'b0;
  endtask

  // Consume the eight bands; mode 0 always ready, 1 random, 2 stall-then-toggle.
  task automatic drain(input int mode, input bit keep);
    int hs, cyc, stall;
    hs = 0; cyc = 0; stall = 0;
    for (int b = 0; b < BN; b++) begin
      cap_d0[b] = -1; cap_p0[b] = -1; cap_d1[b] = -1; hs_order[b] = -1;
    end
    while (hs < BN) begin
      bit r;
      if (cyc >= BUDGET) begin chk("drain_timeout", hs, BN); break; end
      sample_valid = keep;
      sample_in = 16'($urandom);
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(1));
        default: begin
          if (band_valid0 && stall < 5) begin
            chk("stall_idx", int'(band_idx0), 0);
            chk("stall_data", int'(band_data0), 16);
            stall++;
            r = 1'b0;
          end else r = cyc[0];
        end
      endcase
      band_ready = r;
      if (band_valid0 && r) begin
        hs_order[hs] = int'(band_idx0);
        cap_d0[band_idx0] = int'(band_data0);
        cap_p0[band_idx0] = int'(band_peak0);
        cap_d1[band_idx0] = int'(band_data1);
        hs++;
      end
      @(negedge clk); cyc++;
    end
    band_ready = 1'b0; sample_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    sample_valid = 1'b0; sample_in = '0; band_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_valid", int'(band_valid0), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame of constant 0x1000.
    do_start(1'b0);
    feed(0, FL, 0);
    drain(0, 1'b0);
    for (int b = 0; b < BN; b++) begin
      chk("t1_data", cap_d0[b], 16);
      chk("t1_peak", cap_p0[b], 16);
      chk("t1_data_sh10", cap_d1[b], 32);
    end
    chk("t1_done_pulse", int'(frame_done0), 1);
    @(negedge clk);
    chk("t1_done_clear", int'(frame_done0), 0);
    chk("t1_idle", int'(busy0), 0);

    // Full-scale negative band and saturation.
    do_start(1'b0);
    feed(1, FL, 15);
    drain(1, 1'b0);
    chk("t2_b3", cap_d0[3], 128);
    chk("t2_b0", cap_d0[0], 0);
    chk("t2_b3_sh10", cap_d1[3], 255);
    do_start(1'b0);
    feed(2, FL, 0);
    drain(0, 1'b0);
    chk("t2_pos_b3", cap_d0[3], 127);
    chk("t2_pos_b3_sh10", cap_d1[3], 255);

    // Back-pressure: stall then alternate ready.
    do_start(1'b0);
    feed(0, FL, 0);
    drain(2, 1'b0);
    for (int k = 0; k < BN; k++) chk("t4_order", hs_order[k], k);

    // Overrun in single-shot: sticky in IDLE, cleared by start.
    do_start(1'b0);
    feed(0, FL, 20);
    drain(0, 1'b1);
    chk("t5_overrun_set", int'(overrun0), 1);
    @(negedge clk);
    chk("t5_overrun_sticky", int'(overrun0), 1);
    do_start(1'b0);
    chk("t5_overrun_clear", int'(overrun0), 0);
    feed(0, FL, 0);
    drain(0, 1'b0);

    // Continuous mode with peak decay and samples offered during EMIT.
    do_start(1'b1);
    feed(3, FL, 0);
    drain(1, 1'b1);
    chk("t3_f1_data", cap_d0[0], 127);
    chk("t3_f1_peak", cap_p0[0], 127);
    chk("t3_overrun", int'(overrun0), 1);
    feed(4, FL, 10);
    drain(1, 1'b1);
    chk("t3_f2_data", cap_d0[0], 0);
    chk("t3_f2_peak", cap_p0[0], 123);
    feed(4, FL, 0);
    drain(1, 1'b1);
    chk("t3_f3_data", cap_d0[0], 0);
    chk("t3_f3_peak", cap_p0[0], 119);

    // Reset mid-frame, then a clean frame.
    feed(0, 20, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", int'(band_valid0), 0);
    chk("t6_busy", int'(busy0), 0);
    chk("t6_ready", int'(sample_ready0), 0);
    chk("t6_overrun", int'(overrun0), 0);
    chk("t6_idx", int'(band_idx0), 0);
    chk("t6_data", int'(band_data0), 0);
    chk("t6_peak", int'(band_peak0), 0);
    chk("t6_peak_sh10", int'(band_peak1), 0);
    rst = 1'b0;
    @(negedge clk);
    do_start(1'b0);
    feed(0, FL, 10);
    drain(1, 1'b0);
    for (int b = 0; b < BN; b++) begin
      chk("t6_data_after", cap_d0[b], 16);
      chk("t6_peak_after", cap_p0[b], 16);
    end

    // Random frames with idle-time samples that must be ignored.
    for (int f = 0; f < 6; f++) begin
      repeat (3) begin
        sample_valid = 1'($urandom_range(1));
        sample_in = 16'($urandom);
        @(negedge clk);
      end
      sample_valid = 1'b0;
      do_start(1'b0);
      feed(5, FL, int'($urandom_range(40)));
      drain(int'($urandom_range(1)), 1'($urandom_range(1)));
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spectrum_band_engine.md
Name: spectrum_band_engine

Overview:
Parametrised streaming band-energy analyser for the audio spectrum path. It accepts a frame of FRAME_LEN signed samples and sums magnitudes on the fly into BAND_NUM contiguous bands, with no sample RAM. Each band is scaled with saturation to OUT_WIDTH bits and tracked by a per-band decaying peak-hold. Results are streamed to the display/LED driver over a valid/ready interface. The block runs single-shot or continuously.

Parameters:
DATA_WIDTH, 16, signed sample width
FRAME_LEN, 64, samples per frame; power of 2
BAND_NUM, 8, number of bands; power of 2, divides FRAME_LEN
OUT_WIDTH, 8, band output width
OUT_SHIFT, ACC_W-OUT_WIDTH, right shift applied to the band sum before saturation
DECAY_STEP, 4, amount subtracted from each held peak per frame

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a frame; ignored unless the block is IDLE
continuous  in  1  sampled at start; 1 = re-arm automatically after each frame
sample_in  in  DATA_WIDTH  signed sample
sample_valid  in  1  sample_in valid
sample_ready  out  1  high only in COLLECT
band_data  out  OUT_WIDTH  scaled energy of band band_idx
band_peak  out  OUT_WIDTH  held peak of band band_idx
band_idx  out  clog2(BAND_NUM)  current band index
band_valid  out  1  band output valid
band_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse after the last band is accepted
busy  out  1  state != IDLE
overrun  out  1  sticky; a sample was offered while sample_ready was low outside IDLE

Behaviour:
Derived widths:
- SPB = FRAME_LEN/BAND_NUM.
- ACC_W = DATA_WIDTH + log2(SPB).

Reset (async, active-high):
- State goes to IDLE.
- All band and peak registers clear to 0.
- band_idx = 0; band_valid, sample_ready, frame_done, busy and overrun are all 0.
- Reset mid-frame discards partial sums.

States:
- IDLE: on start, latch continuous, clear overrun and the accumulator, zero the sample counter, go to COLLECT. Peaks are not cleared by start.
- COLLECT: a sample is accepted on any edge where sample_valid is high. The accumulator adds |sample|. |x| is computed at DATA_WIDTH+1 bits so that -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1).
- Band boundary: on the edge that accepts the SPB-th sample of a band, the following happen on that same edge:
  - band[b] <= min(sum >> OUT_SHIFT, 2^OUT_WIDTH-1), where sum includes the current sample.
  - d = (peak[b] > DECAY_STEP) ? peak[b]-DECAY_STEP : 0.
  - peak[b] <= max(band[b]_new, d).
  - The accumulator clears.
- After the edge that accepts the FRAME_LEN-th sample, the state is EMIT with band_idx = 0. band_valid is high in the very next cycle, which is 1-cycle latency from the last sample to the first band.
- EMIT:
  - band_valid = 1.
  - band_data and band_peak present the band_idx entries and stay stable while band_ready = 0.
  - On valid&ready, band_idx increments.
  - On acceptance of band BAND_NUM-1, frame_done pulses high for the next cycle and band_valid drops. The next state is COLLECT if the latched continuous = 1, otherwise IDLE.
- sample_ready = 0 in EMIT. A sample offered in EMIT is dropped and sets overrun. Samples offered in IDLE are ignored silently.
- start during COLLECT or EMIT has no effect.
- In continuous mode, the band and peak registers persist across frames, so decay accumulates frame over frame.

Decomposition:
- Shared package spectrum_pkg holds:
  - state encoding (IDLE/COLLECT/EMIT);
  - clog2 helper;
  - default widths (DATA_WIDTH 16, OUT_WIDTH 8).
- One natural sub-module, band_scale_peak: combinational. It takes sum, old peak, OUT_SHIFT and DECAY_STEP, and returns the saturated band value and the new peak. It is unit-testable alone.

Test Plan:
All scenarios use default parameters (SPB = 8, ACC_W = 19, OUT_SHIFT = 11).
1. start, continuous=0; 64 samples of 0x1000 -> all band_data = 16 and band_peak = 16; band_idx runs 0..7; frame_done single pulse; return to IDLE; busy = 0.
2. Band 3 samples = -32768, all other samples 0 -> band 3 = 128 (sum 262144), others 0. Then override OUT_SHIFT=10 with band 3 samples 0x7FFF -> band 3 saturates to 255.
3. continuous=1; frame 1 band 0 = 0x7FFF (band = 127); frames 2 and 3 all zeros -> band_peak[0] reads 127, then 123, then 119; band_data[0] = 0 on frames 2 and 3.
4. Hold band_ready = 0 for 5 cycles in EMIT -> band_idx = 0 and band_data stable throughout. Then toggle band_ready every other cycle -> exactly 8 handshakes, no skipped bands.
5. Assert sample_valid continuously through EMIT in continuous mode -> sample_ready = 0 and overrun = 1. Next frame's sums count only samples accepted in COLLECT. overrun clears on the next start from IDLE.
6. Assert rst after 20 samples -> next-cycle outputs all zero, state IDLE. A fresh start followed by 64 × 0x1000 gives 16 in every band.
